// File: rtl/d_latch.sv
// d_latch: gated D latch built from a clocked hold register and a transparent output mux
module d_latch #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             e,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             q_valid,
  output logic             closed
);
  logic [WIDTH-1:0] hold_d, hold_q;
  logic             valid_d, valid_q, e_d, e_q;
  always_comb begin
    hold_d  = e ? d : hold_q;
    valid_d = e | valid_q;
    e_d     = e;
    q       = e ? d : hold_q;
    q_bar   = ~q;
    q_valid = valid_q;
    closed  = rst_n & e_q & ~e;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q  <= RST_VAL;
      valid_q <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
      e_q     <= e_d;
    end
  end
endmodule

// File: tb/tb_d_latch.sv
// tb_d_latch: directed and random checks of d_latch (1-bit and 8-bit) against a behavioural model
`timescale 1ns/100ps
module tb_d_latch;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       e = 1'b0;
  logic       d1 = 1'b1;
  logic [7:0] d8 = 8'h00;
  logic       q1, qb1, qv1, cl1;
  logic [7:0] q8, qb8;
  logic       qv8, cl8;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       m_cap1 = 1'b0;
  logic [7:0] m_cap8 = 8'hA5;
  logic       m_valid = 1'b0;
  logic       m_eprev = 1'b0;

  always #5 clk = ~clk;

  d_latch u1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .e(e),
    .q(q1), .q_bar(qb1), .q_valid(qv1), .closed(cl1)
  );

  d_latch #(.WIDTH(8), .RST_VAL(8'hA5)) u8 (
    .clk(clk), .rst_n(rst_n), .d(d8), .e(e),
    .q(q8), .q_bar(qb8), .q_valid(qv8), .closed(cl8)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: remember what d was at the most recent edge with e=1 since the last reset
  always @(posedge clk) begin
    if (!rst_n) begin
      m_cap1 = 1'b0;
      m_cap8 = 8'hA5;
      m_valid = 1'b0;
      m_eprev = 1'b0;
    end else begin
      if (e) begin
        m_cap1 = d1;
        m_cap8 = d8;
        m_valid = 1'b1;
      end
      m_eprev = e;
    end
  end

  always @(negedge clk) begin
    logic       x1;
    logic [7:0] x8;
    logic       xc;
    x1 = e ? d1 : m_cap1;
    x8 = e ? d8 : m_cap8;
    xc = rst_n && m_eprev && !e;
    chk("q1", {7'b0, q1}, {7'b0, x1});
    chk("q_bar1", {7'b0, qb1}, {7'b0, ~x1});
    chk("q_valid1", {7'b0, qv1}, {7'b0, m_valid});
    chk("closed1", {7'b0, cl1}, {7'b0, xc});
    chk("q8", q8, x8);
    chk("q_bar8", qb8, ~x8);
    chk("q_valid8", {7'b0, qv8}, {7'b0, m_valid});
    chk("closed8", {7'b0, cl8}, {7'b0, xc});
  end

  task automatic step(input logic en, input logic dv1, input logic [7:0] dv8);
    @(posedge clk);
    #2;
    e = en;
    d1 = dv1;
    d8 = dv8;
    #1;
  endtask

  initial begin
    // reset for two edges with e=0, d=1
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", {7'b0, q1}, 8'h00);
    chk("rst_q_bar", {7'b0, qb1}, 8'h01);
    chk("rst_q_valid", {7'b0, qv1}, 8'h00);
    chk("rst_closed", {7'b0, cl1}, 8'h00);
    chk("rst_q8", q8, 8'hA5);
    chk("rst_q_bar8", qb8, 8'h5A);
    rst_n = 1'b1;
    // sweep {e,d}
    step(1'b0, 1'b0, 8'h00); chk("sw00_q", {7'b0, q1}, 8'h00); chk("sw00_qb", {7'b0, qb1}, 8'h01);
    step(1'b0, 1'b1, 8'h00); chk("sw01_q", {7'b0, q1}, 8'h00); chk("sw01_qb", {7'b0, qb1}, 8'h01);
    step(1'b1, 1'b0, 8'h00); chk("sw10_q", {7'b0, q1}, 8'h00); chk("sw10_qb", {7'b0, qb1}, 8'h01);
    step(1'b1, 1'b1, 8'h00); chk("sw11_q", {7'b0, q1}, 8'h01); chk("sw11_qb", {7'b0, qb1}, 8'h00);
    // capture 1 then close
    step(1'b0, 1'b0, 8'h00);
    chk("hold_q", {7'b0, q1}, 8'h01);
    chk("hold_valid", {7'b0, qv1}, 8'h01);
    chk("closed_pulse", {7'b0, cl1}, 8'h01);
    step(1'b0, 1'b0, 8'h00);
    chk("closed_drop", {7'b0, cl1}, 8'h00);
    chk("hold_q2", {7'b0, q1}, 8'h01);
    // reset with e=0 acts only at the next edge
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_pre_edge_q", {7'b0, q1}, 8'h01);
    @(posedge clk);
    #1 chk("rst_post_edge_q", {7'b0, q1}, 8'h00);
    chk("rst_post_edge_qb", {7'b0, qb1}, 8'h01);
    chk("rst_post_edge_valid", {7'b0, qv1}, 8'h00);
    #1 rst_n = 1'b1;
    // transparency: q tracks d between edges
    @(negedge clk);
    #0.5 e = 1'b1;
    d1 = 1'b0;
    #1 chk("transp_0", {7'b0, q1}, 8'h00);
    d1 = 1'b1;
    #1 chk("transp_1", {7'b0, q1}, 8'h01);
    d1 = 1'b0;
    #1 chk("transp_0b", {7'b0, q1}, 8'h00);
    // 8-bit capture
    step(1'b1, 1'b0, 8'h3C);
    chk("w8_transp", q8, 8'h3C);
    step(1'b0, 1'b0, 8'hFF);
    chk("w8_hold", q8, 8'h3C);
    chk("w8_hold_bar", qb8, 8'hC3);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      rst_n = ($urandom_range(15) != 0);
      e = 1'($urandom_range(1));
      d1 = 1'($urandom_range(1));
      d8 = 8'($urandom_range(255));
      if ($urandom_range(3) == 0) begin
        #1 d1 = ~d1;
        d8 = 8'($urandom_range(255));
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
